// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one full-page-burst SDRAM controller between a write stream
//   (capture FIFO) and a read stream (display FIFO). Each grant issues one
//   page burst. Each port keeps its own page counter, which wraps at the
//   frame size. The data buses pass straight through. Only the controller's
//   rw/rw_en/addr/ready handshake is arbitrated.
//
// Ports
//   clk, rst_n           controller clock, async active-low reset
//   wr_req               write FIFO holds a full burst
//   wr_frame_start       restart write page counter
//   wr_data / wr_data_rd write FIFO head word / pop strobe
//   rd_req               read FIFO has room for a full burst
//   rd_frame_start       restart read page counter
//   rd_data / rd_data_valid  word / push strobe to the read FIFO
//   wr_frame_done        pulse after the last page of a frame is written
//   rd_frame_done        pulse after the last page of a frame is read
//   busy                 burst in flight
//   grant_rd             current/last burst is a read
//   burst_err            sticky: a burst ended with the wrong beat count
//   c_*                  controller handshake and data
module sdram_port_arbiter #(
  parameter int BURST_LEN   = 512,
  parameter int FRAME_PAGES = 600,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              wr_frame_start,
  input  logic [15:0]       wr_data,
  output logic              wr_data_rd,
  input  logic              rd_req,
  input  logic              rd_frame_start,
  output logic [15:0]       rd_data,
  output logic              rd_data_valid,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              busy,
  output logic              grant_rd,
  output logic              burst_err,
  output logic              c_rw,
  output logic              c_rw_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [15:0]       c_f2s_data,
  input  logic              c_f2s_data_valid,
  input  logic [15:0]       c_s2f_data,
  input  logic              c_s2f_data_valid,
  input  logic              c_ready
);

  typedef enum logic [2:0] {S_ARB, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(FRAME_PAGES - 1);
  localparam logic [9:0]        BEATS_EXP = 10'(BURST_LEN);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_page;
  logic [ADDR_W-1:0] r_rd_page;
  logic              r_last_rd;
  logic              r_wr_restart;
  logic              r_rd_restart;
  logic [9:0]        r_beats;
  logic              r_c_rw;
  logic              r_c_rw_en;
  logic [ADDR_W-1:0] r_c_addr;
  logic              r_busy;
  logic              r_grant_rd;
  logic              r_wr_done;
  logic              r_rd_done;
  logic              r_err;

  logic              w_wr_active;
  logic              w_rd_active;
  logic              w_pick_rd;
  logic              w_beat;
  logic [ADDR_W-1:0] w_wr_page_eff;
  logic [ADDR_W-1:0] w_rd_page_eff;

  assign w_wr_active = r_busy & ~r_grant_rd;
  assign w_rd_active = r_busy &  r_grant_rd;
  // Read wins if it is alone, or if both request and the last grant was a write.
  assign w_pick_rd   = rd_req & (~wr_req | ~r_last_rd);
  assign w_beat      = (w_wr_active & c_f2s_data_valid) | (w_rd_active & c_s2f_data_valid);
  // A restart arriving in the same cycle as a grant must address page 0.
  assign w_wr_page_eff = wr_frame_start ? '0 : r_wr_page;
  assign w_rd_page_eff = rd_frame_start ? '0 : r_rd_page;

  assign c_f2s_data    = wr_data;
  assign wr_data_rd    = c_f2s_data_valid & w_wr_active;
  assign rd_data       = c_s2f_data;
  assign rd_data_valid = c_s2f_data_valid & w_rd_active;

  assign c_rw          = r_c_rw;
  assign c_rw_en       = r_c_rw_en;
  assign c_addr        = r_c_addr;
  assign busy          = r_busy;
  assign grant_rd      = r_grant_rd;
  assign wr_frame_done = r_wr_done;
  assign rd_frame_done = r_rd_done;
  assign burst_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ARB;
      r_wr_page    <= '0;
      r_rd_page    <= '0;
      r_last_rd    <= 1'b0;
      r_wr_restart <= 1'b0;
      r_rd_restart <= 1'b0;
      r_beats      <= '0;
      r_c_rw       <= 1'b0;
      r_c_rw_en    <= 1'b0;
      r_c_addr     <= '0;
      r_busy       <= 1'b0;
      r_grant_rd   <= 1'b0;
      r_wr_done    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_c_rw_en <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;

      case (r_state)
        S_ARB: begin
          if (c_ready && (rd_req || wr_req)) begin
            r_grant_rd <= w_pick_rd;
            r_c_rw     <= w_pick_rd;
            r_c_addr   <= w_pick_rd ? w_rd_page_eff : w_wr_page_eff;
            r_c_rw_en  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE:     r_state <= S_WAIT_LOW;
        // ready falling is the controller's acknowledge of the request
        S_WAIT_LOW:  if (!c_ready) r_state <= S_WAIT_HIGH;
        S_WAIT_HIGH: if (c_ready)  r_state <= S_DONE;
        S_DONE: begin
          if (r_beats != BEATS_EXP) r_err <= 1'b1;
          r_last_rd <= r_grant_rd;
          r_busy    <= 1'b0;
          r_state   <= S_ARB;
        end
        default: r_state <= S_ARB;
      endcase

      if (r_state == S_DONE)
        r_beats <= '0;
      else if (w_beat)
        r_beats <= r_beats + 10'd1;

      // Write page counter: restarts during a burst are deferred to DONE.
      if (w_wr_active) begin
        if (r_state == S_DONE) begin
          r_wr_restart <= 1'b0;
          if (r_wr_restart || wr_frame_start) begin
            r_wr_page <= '0;
          end else if (r_wr_page == LAST_PAGE) begin
            r_wr_page <= '0;
            r_wr_done <= 1'b1;
          end else begin
            r_wr_page <= r_wr_page + 1'b1;
          end
        end else if (wr_frame_start) begin
          r_wr_restart <= 1'b1;
        end
      end else if (wr_frame_start) begin
        r_wr_page <= '0;
      end

      // Read page counter: same scheme as the write side.
      if (w_rd_active) begin
        if (r_state == S_DONE) begin
          r_rd_restart <= 1'b0;
          if (r_rd_restart || rd_frame_start) begin
            r_rd_page <= '0;
          end else if (r_rd_page == LAST_PAGE) begin
            r_rd_page <= '0;
            r_rd_done <= 1'b1;
          end else begin
            r_rd_page <= r_rd_page + 1'b1;
          end
        end else if (rd_frame_start) begin
          r_rd_restart <= 1'b1;
        end
      end else if (rd_frame_start) begin
        r_rd_page <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int BL = 512;
  localparam int FP = 4;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req, wr_frame_start, rd_frame_start;
  logic [15:0]   wr_data;
  logic          wr_data_rd, rd_data_valid;
  logic [15:0]   rd_data;
  logic          wr_frame_done, rd_frame_done, busy, grant_rd, burst_err;
  logic          c_rw, c_rw_en;
  logic [AW-1:0] c_addr;
  logic [15:0]   c_f2s_data;
  logic          c_f2s_data_valid, c_s2f_data_valid, c_ready;
  logic [15:0]   c_s2f_data;

  // controller model drives m_*, table vectors drive t_*
  logic        m_ready, m_f2s_v, m_s2f_v;
  logic [15:0] m_s2f_data;
  logic        t_f2s_v, t_s2f_v;
  logic [15:0] t_s2f_data;
  int          m_burst_no;
  int          short_at;

  assign c_ready          = m_ready;
  assign c_f2s_data_valid = m_f2s_v | t_f2s_v;
  assign c_s2f_data_valid = m_s2f_v | t_s2f_v;
  assign c_s2f_data       = m_s2f_data | t_s2f_data;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.BURST_LEN(BL), .FRAME_PAGES(FP), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_frame_start(wr_frame_start), .wr_data(wr_data),
    .wr_data_rd(wr_data_rd),
    .rd_req(rd_req), .rd_frame_start(rd_frame_start), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
    .busy(busy), .grant_rd(grant_rd), .burst_err(burst_err),
    .c_rw(c_rw), .c_rw_en(c_rw_en), .c_addr(c_addr), .c_f2s_data(c_f2s_data),
    .c_f2s_data_valid(c_f2s_data_valid), .c_s2f_data(c_s2f_data),
    .c_s2f_data_valid(c_s2f_data_valid), .c_ready(c_ready)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------- controller model ----------------
  initial begin
    m_ready = 1'b1; m_f2s_v = 1'b0; m_s2f_v = 1'b0; m_s2f_data = '0;
    m_burst_no = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && c_rw_en) begin
        logic rw;
        int   n;
        rw = c_rw;
        n  = (m_burst_no == short_at) ? BL - 1 : BL;
        m_burst_no++;
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
          if (!rst_n) break;
          if (rw) begin m_s2f_v = 1'b1; m_s2f_data = 16'hA000 + 16'(i); end
          else m_f2s_v = 1'b1;
          @(posedge clk); #1;
        end
        m_f2s_v = 1'b0; m_s2f_v = 1'b0; m_s2f_data = '0;
        for (int k = 0; k < 3 && rst_n; k++) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] exp_q[$];
  int iss_cnt = 0, done_cnt = 0, cur_wr = 0, cur_rd = 0, last_wr = 0, last_rd = 0;
  int wfd_n = 0, rfd_n = 0, wfd_at = 0, wfd_run = 0, rfd_run = 0, fd_max = 0;
  int rwen_bad = 0, data_bad = 0;
  logic prev_busy = 1'b0, prev_rwen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; prev_rwen = 1'b0; wfd_run = 0; rfd_run = 0;
      end else begin
        if (c_rw_en) begin
          iss_cnt++; cur_wr = 0; cur_rd = 0;
          if (prev_rwen) rwen_bad++;
          if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL grant: got unexpected issue rw=%0d addr=%0d, required none", c_rw, c_addr);
          end else begin
            chk("grant {rw,addr}", {16'h0, c_rw, c_addr}, {16'h0, exp_q.pop_front()});
          end
        end
        if (wr_data_rd) cur_wr++;
        if (rd_data_valid) begin
          cur_rd++;
          if (rd_data !== c_s2f_data) data_bad++;
        end
        if (prev_busy && !busy) begin
          done_cnt++; last_wr = cur_wr; last_rd = cur_rd;
        end
        if (wr_frame_done) begin
          if (wfd_run == 0) begin wfd_n++; wfd_at = done_cnt; end
          wfd_run++; if (wfd_run > fd_max) fd_max = wfd_run;
        end else wfd_run = 0;
        if (rd_frame_done) begin
          if (rfd_run == 0) rfd_n++;
          rfd_run++; if (rfd_run > fd_max) fd_max = rfd_run;
        end else rfd_run = 0;
        prev_busy = busy; prev_rwen = c_rw_en;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    if (done_cnt < target) begin
      n_tot++;
      $display("FAIL burst_timeout: got %0d bursts, required %0d", done_cnt, target);
    end
  endtask

  task automatic wait_issue(input int target);
    int t = 0;
    while (iss_cnt < target && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    if (iss_cnt < target) begin
      n_tot++;
      $display("FAIL issue_timeout: got %0d issues, required %0d", iss_cnt, target);
    end
  endtask

  function automatic logic [15:0] g(input logic rw, input int a);
    return {rw, 15'(a)};
  endfunction

  typedef struct {
    logic        f2s_v;
    logic        s2f_v;
    logic [15:0] wd;
    logic [15:0] sd;
    logic        exp_wrd;
    logic        exp_rdv;
    logic [15:0] exp_f2s;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt[4];

  // ---------------- main sequence ----------------
  initial begin
    int b, bi;
    rst_n = 1'b0; wr_req = 0; rd_req = 0; wr_frame_start = 0; rd_frame_start = 0;
    wr_data = 16'h0; t_f2s_v = 0; t_s2f_v = 0; t_s2f_data = '0; short_at = -1;

    vt[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 16'hBEEF, 16'h0F0F, 1'b0, 1'b0, 16'hBEEF, 16'h0F0F};
    vt[2] = '{1'b0, 1'b1, 16'h5555, 16'hCAFE, 1'b0, 1'b0, 16'h5555, 16'hCAFE};
    vt[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h8001, 1'b0, 1'b0, 16'hFFFF, 16'h8001};

    #2;
    chk("reset outputs", {24'h0, c_rw_en, c_rw, busy, grant_rd, wr_frame_done,
        rd_frame_done, burst_err, |c_addr}, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // idle data path: valids are dropped, data passes through
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      t_f2s_v = vt[i].f2s_v; t_s2f_v = vt[i].s2f_v;
      wr_data = vt[i].wd;    t_s2f_data = vt[i].sd;
      #1;
      chk($sformatf("vec%0d wr_data_rd", i), wr_data_rd, vt[i].exp_wrd);
      chk($sformatf("vec%0d rd_data_valid", i), rd_data_valid, vt[i].exp_rdv);
      chk($sformatf("vec%0d c_f2s_data", i), c_f2s_data, vt[i].exp_f2s);
      chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].exp_rd);
    end
    @(negedge clk);
    t_f2s_v = 0; t_s2f_v = 0; t_s2f_data = '0;
    chk("idle no issue", iss_cnt, 0);

    // write only: two bursts, pages 0 then 1
    b = done_cnt;
    exp_q.push_back(g(0, 0)); exp_q.push_back(g(0, 1));
    wr_req = 1;
    wait_done(b + 1);
    chk("wr burst1 pops", last_wr, BL);
    chk("wr burst1 err", burst_err, 0);
    wait_done(b + 2);
    wr_req = 0;
    chk("wr burst2 pops", last_wr, BL);
    chk("wr burst2 err", burst_err, 0);

    // both requesting: read, write, read, write
    do_reset();
    b = done_cnt;
    exp_q.push_back(g(1, 0)); exp_q.push_back(g(0, 0));
    exp_q.push_back(g(1, 1)); exp_q.push_back(g(0, 1));
    wr_req = 1; rd_req = 1;
    wait_done(b + 1);
    chk("rr read pushes", last_rd, BL);
    wait_done(b + 4);
    wr_req = 0; rd_req = 0;
    chk("rr queue drained", exp_q.size(), 0);

    // write frame wrap with FRAME_PAGES=4
    do_reset();
    b = done_cnt; bi = wfd_n;
    for (int p = 0; p < 5; p++) exp_q.push_back(g(0, p % FP));
    wr_req = 1;
    wait_done(b + 5);
    wr_req = 0;
    chk("wr_frame_done count", wfd_n - bi, 1);
    chk("wr_frame_done burst", wfd_at - b, 4);
    chk("frame_done width", fd_max, 1);
    chk("wrap queue drained", exp_q.size(), 0);

    // read frame restart mid-burst of page 2
    do_reset();
    b = done_cnt; bi = rfd_n;
    exp_q.push_back(g(1, 0)); exp_q.push_back(g(1, 1));
    exp_q.push_back(g(1, 2)); exp_q.push_back(g(1, 0));
    rd_req = 1;
    wait_issue(iss_cnt + 3);
    repeat (100) @(negedge clk);
    rd_frame_start = 1;
    @(negedge clk);
    rd_frame_start = 0;
    wait_done(b + 3);
    chk("restart burst pushes", last_rd, BL);
    wait_done(b + 4);
    rd_req = 0;
    chk("restart no rd_frame_done", rfd_n - bi, 0);
    chk("restart queue drained", exp_q.size(), 0);

    // short read burst makes burst_err sticky
    do_reset();
    b = done_cnt;
    short_at = m_burst_no;
    exp_q.push_back(g(1, 0)); exp_q.push_back(g(1, 1)); exp_q.push_back(g(1, 2));
    rd_req = 1;
    wait_done(b + 1);
    chk("short burst beats", last_rd, BL - 1);
    chk("burst_err set", burst_err, 1);
    wait_done(b + 3);
    rd_req = 0;
    chk("burst_err sticky", burst_err, 1);
    do_reset();
    chk("burst_err cleared by reset", burst_err, 0);

    // reset in the middle of a write burst
    b = done_cnt;
    exp_q.push_back(g(0, 0));
    wr_req = 1;
    wait_issue(iss_cnt + 1);
    repeat (60) @(negedge clk);
    chk("mid-burst busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {22'h0, c_rw_en, c_rw, busy, grant_rd, wr_frame_done,
        rd_frame_done, burst_err, wr_data_rd, rd_data_valid, |c_addr}, 32'h0);
    exp_q.push_back(g(0, 0));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_done(b + 1);
    wr_req = 0;
    chk("post-reset burst pops", last_wr, BL);
    chk("final queue drained", exp_q.size(), 0);
    chk("rw_en single cycle", rwen_bad, 0);
    chk("rd_data passthrough", data_bad, 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
